// File: rtl/prio_irq_pkg.sv
// ---------------------------------------------------------------------------
// prio_irq_pkg
//   Shared definitions for the priority interrupt encoder:
//     - state_e      : presenter FSM encoding (IDLE=0, PRESENT=1)
//     - none_idx()   : all-ones "no channel" index for a given index width
// ---------------------------------------------------------------------------
package prio_irq_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // All-ones value in the low w bits; used as the OUT value when nothing is
    // being presented. w is at most 5 for the supported channel counts.
    function automatic logic [31:0] none_idx(input int unsigned w);
        none_idx = (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/prio_find.sv
// ---------------------------------------------------------------------------
// prio_find
//   Combinational search for the first set bit of vec, starting at bit
//   position base and descending, wrapping from 0 back to N-1.
//   With base = N-1 this is a plain fixed-priority encoder (MSB wins).
//
//   Ports
//     vec   : candidate vector, one bit per channel
//     base  : first position examined (highest priority for this search)
//     idx   : index of the winning channel (0 when found=0)
//     found : at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_find #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int           p;
        logic [W-1:0] cand;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // Position k steps below base, modulo N (N need not be a power
            // of two, so the wrap is done explicitly).
            p = int'(base) - k;
            if (p < 0) begin
                p = p + N;
            end
            cand = W'(p);
            if (!found && vec[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/prio_irq_encoder.sv
// ---------------------------------------------------------------------------
// prio_irq_encoder
//   Edge-detecting interrupt collector with a single presented index.
//   Rising edges on IN set per-channel pending bits; an IDLE/PRESENT FSM
//   latches the highest-priority unmasked pending channel onto OUT and holds
//   it until the consumer acknowledges it.
//
//   Handshake: VALID=1 means OUT names a pending channel. The presentation is
//   transferred on a rising CLK edge where VALID=1 and ACK=1; that edge clears
//   the channel's pending bit and VALID drops for at least one cycle. ACK with
//   VALID=0 has no effect. OUT/VALID never change while VALID=1 and ACK=0.
//
//   Ports
//     CLK   : clock, rising edge
//     RST_N : asynchronous active-low reset
//     IN    : [N_IN] level request lines, edge-detected internally
//     MASK  : [N_IN] 1 = channel not eligible for selection (still recorded)
//     ACK   : consumer accepts the presented index
//     OUT   : [IDX_W] presented index, all-ones when VALID=0
//     VALID : OUT holds a pending, selected channel
//     OVR   : one-cycle pulse when an edge hits an already pending channel
//
//   Configuration
//     PRIO_IRQ_RR_EN : when defined, rotating priority. After ACK of index k
//                      the search starts at k-1 (wrapping) and descends.
//                      When undefined, fixed priority, N_IN-1 highest.
// ---------------------------------------------------------------------------
module prio_irq_encoder
    import prio_irq_pkg::*;
#(
    parameter  int N_IN  = 8,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_IN-1:0]  IN,
    input  logic [N_IN-1:0]  MASK,
    input  logic             ACK,
    output logic [IDX_W-1:0] OUT,
    output logic             VALID,
    output logic             OVR
);

    localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(none_idx(IDX_W));
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N_IN - 1);

    // FSM state is a plain named signal so checkers can bind to it.
    state_e           state;
    state_e           state_nxt;

    logic [N_IN-1:0]  in_d;
    logic [N_IN-1:0]  pending;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  eligible;
    logic [N_IN-1:0]  clr;
    logic             ack_take;

    logic [IDX_W-1:0] out_q;
    logic [IDX_W-1:0] out_nxt;
    logic             valid_q;
    logic             valid_nxt;
    logic             ovr_q;

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] find_idx;
    logic             find_found;

    // -----------------------------------------------------------------------
    // Edge detection and pending bookkeeping
    // -----------------------------------------------------------------------
    assign rise     = IN & ~in_d;
    assign eligible = pending & ~MASK;
    assign ack_take = (state == PRESENT) && ACK;
    assign clr      = ack_take ? (N_IN'(1) << out_q) : '0;

    // -----------------------------------------------------------------------
    // Search start position
    // -----------------------------------------------------------------------
`ifdef PRIO_IRQ_RR_EN
    logic [IDX_W-1:0] ptr;

    // Pointer moves to just below the channel that was served, so that
    // channel becomes the lowest priority for the next search.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= TOP_IDX;
        end else if (ack_take) begin
            ptr <= (out_q == '0) ? TOP_IDX : (out_q - 1'b1);
        end
    end

    assign base = ptr;
`else
    assign base = TOP_IDX;
`endif

    prio_find #(
        .N (N_IN)
    ) u_find (
        .vec   (eligible),
        .base  (base),
        .idx   (find_idx),
        .found (find_found)
    );

    // -----------------------------------------------------------------------
    // Presenter FSM: next state and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        out_nxt   = out_q;
        valid_nxt = valid_q;
        case (state)
            IDLE: begin
                if (find_found) begin
                    out_nxt   = find_idx;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end else begin
                    out_nxt   = NONE_IDX;
                    valid_nxt = 1'b0;
                end
            end
            PRESENT: begin
                // Held regardless of new requests or MASK changes; only ACK
                // releases the presentation.
                if (ACK) begin
                    out_nxt   = NONE_IDX;
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                out_nxt   = NONE_IDX;
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            out_q   <= NONE_IDX;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            pending <= '0;
            in_d    <= '0;
        end else begin
            state   <= state_nxt;
            out_q   <= out_nxt;
            valid_q <= valid_nxt;
            in_d    <= IN;
            // Set wins over a coincident ACK clear of the same channel.
            pending <= (pending & ~clr) | rise;
            // A coincident clear makes the new edge a fresh event, not an
            // overrun.
            ovr_q   <= |(rise & pending & ~clr);
        end
    end

    assign OUT   = out_q;
    assign VALID = valid_q;
    assign OVR   = ovr_q;

endmodule

// File: doc/prio_irq_encoder.md
PRIO_IRQ_ENCODER -- requirements
Module: prio_irq_encoder

Interface
REQ-001 The block SHALL have parameter N_IN, default 8, giving the number of request inputs (legal range 2..32).
REQ-002 The block SHALL have localparam IDX_W = $clog2(N_IN), default 3, giving the width of the index.
REQ-003 Port CLK SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port RST_N SHALL be input, 1 bit: the reset, asynchronous and active-low.
REQ-005 Port IN SHALL be input, N_IN bits: request lines, one per channel, level inputs edge-detected internally.
REQ-006 Port MASK SHALL be input, N_IN bits: 1 = channel excluded from selection.
REQ-007 Port ACK SHALL be input, 1 bit: consumer accepts the presented index.
REQ-008 Port OUT SHALL be output, IDX_W bits: presented channel index; all-ones when VALID=0.
REQ-009 Port VALID SHALL be output, 1 bit: OUT holds a pending, selected channel.
REQ-010 Port OVR SHALL be output, 1 bit: one-cycle pulse when a new edge arrives on a channel whose pending bit is already set.

Function
REQ-011 The block SHALL register IN into IN_D each cycle; rise[i] = IN[i] & ~IN_D[i].
REQ-012 On rise[i], the block SHALL set pending[i] at that edge.
REQ-013 The FSM SHALL have two states, IDLE and PRESENT.
REQ-014 In IDLE, if eligible = pending & ~MASK is non-zero, the block SHALL latch the highest-priority eligible index into OUT, set VALID=1 and enter PRESENT.
REQ-015 In IDLE with eligible = 0, the block SHALL hold VALID=0 and OUT all-ones.
REQ-016 In PRESENT, OUT and VALID SHALL be held stable until ACK=1; a later higher-priority request SHALL NOT preempt.
REQ-017 In PRESENT with ACK=1, the block SHALL clear pending[OUT], drive VALID=0 and OUT all-ones next cycle, and enter IDLE.
REQ-018 ACK while in IDLE SHALL be ignored.
REQ-019 Latency: rise sampled at edge k gives pending at k and VALID=1 at edge k+1 when in IDLE; back-to-back grants SHALL have exactly one VALID=0 cycle between them.
REQ-020 If rise[i] coincides with the ACK clear of channel i, set SHALL win: pending[i] stays 1 and OVR SHALL NOT pulse.
REQ-021 If rise[i] occurs while pending[i]=1 and there is no coincident clear, OVR SHALL pulse high for one cycle; pending SHALL stay 1 (events merge).
REQ-022 MASK SHALL gate selection only: masked pending bits SHALL be retained, and changing MASK in PRESENT SHALL NOT withdraw OUT.
REQ-023 Fixed priority: index N_IN-1 is highest and index 0 is lowest.

Reset
REQ-024 With RST_N=0 the following SHALL be forced asynchronously: pending=0, IN_D=0, state=IDLE, VALID=0, OUT=all-ones, OVR=0, rotation pointer=N_IN-1.
REQ-025 Assertion of RST_N mid-PRESENT SHALL discard the presented index and all pending events.
REQ-026 Deassertion SHALL be synchronised by the system; the first active edge samples IN, so a line already high at reset release yields a rise.

Configuration
REQ-027 Macro PRIO_IRQ_RR_EN, when defined, SHALL compile in rotating priority: after ACK of index k, the pointer becomes k-1 (wrapping 0 to N_IN-1), and the search starts at the pointer and descends with wrap.
REQ-028 Without PRIO_IRQ_RR_EN, the block SHALL have no pointer register and SHALL use fixed priority per REQ-023.

Structure
REQ-029 Package prio_irq_pkg SHALL hold the FSM state encoding (IDLE=0, PRESENT=1) and the all-ones "none" index constant function of IDX_W.
REQ-030 Sub-module prio_find SHALL implement the combinational search: inputs vector and base pointer, outputs index and found, with base tied to N_IN-1 in fixed mode.

Verification (N_IN=8)
REQ-031 Test 1 SHALL check priority order: IN 0x00->0x24 -> VALID two edges later, OUT=5; ACK -> VALID=0 for one cycle, then OUT=2; ACK -> OUT=7 (all-ones), VALID=0.
REQ-032 Test 2 SHALL check no preemption: OUT=1 presented, then IN[6] rises -> OUT stays 1 until ACK, then OUT=6.
REQ-033 Test 3 SHALL check masking: MASK=0x80, IN rises 0x81 -> OUT=0; after ACK, MASK=0 -> OUT=7.
REQ-034 Test 4 SHALL check overrun and the coincidence rule: IN[3] pulses twice before ACK -> OVR pulses once and one grant results; IN[3] rises on the ACK cycle of 3 -> no OVR and 3 is re-presented.
REQ-035 Test 5 SHALL check reset mid-operation: RST_N low during PRESENT with pending 0x0F -> VALID=0, OUT=7 immediately, and no grants after release with IN held low.
REQ-036 Test 6 (PRIO_IRQ_RR_EN) SHALL check rotation: all channels pending -> grant order 7,6,5,...,0; after ACK of 4 with pending {7,5}, the next grant is 7.
